chip8_timer_ctrl: RTL and testbench
===================================

Name: chip8_timer_ctrl

Overview:
- Sequences the Chip-8 delay timer (DT) and sound timer (ST) instances for the CPU.
- Generates the shared 60 Hz single-cycle tick from the 50 MHz system clock.
- Accepts CPU timer requests over a valid/ready handshake: LD DT,Vx; LD ST,Vx; LD Vx,DT.
- Drives the timers' write strobes and data, returns DT reads, and ensures a tick is never lost to a coincident write.

Parameters:
- CLK_DIV, 833333: system clocks per 60 Hz tick (50e6/60, truncated); legal range ≥ 2.
- CNT_W, $clog2(CLK_DIV): prescaler counter width (derived; not overridden).

Ports:
- clk  in  1  50 MHz system clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_op  in  2  timer_op_t: 0 = WR_DT, 1 = WR_ST, 2 = RD_DT, 3 = reserved.
- req_data  in  8  write value (Vx).
- req_ready  out  1  controller can accept a request.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  8  DT value for RD_DT; 0 otherwise.
- resp_err  out  1  set with resp_valid for the reserved op.
- dt_we  out  1  delay timer write_enable.
- st_we  out  1  sound timer write_enable.
- tmr_wdata  out  8  shared timer write data.
- tick_60  out  1  shared 60 Hz pulse to both timers.
- dt_value  in  8  delay timer registered count.
- st_active  in  1  sound timer nonzero flag.
- sound_on  out  1  buzzer enable.

Behaviour:
- Reset: all outputs 0; prescaler = 0; tick_pending = 0; FSM = IDLE.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - The cycle on which it wraps raises raw_tick for that one cycle.
- Tick deferral:
  - tick_60 = (raw_tick | tick_pending) & ~(dt_we | st_we).
  - If raw_tick coincides with a write strobe, set tick_pending. It is cleared on the cycle tick_60 fires.
  - Writes are never back-to-back, so deferral is at most 1 cycle.
  - Tick rate is exact over the long term.
- FSM states: IDLE, WRITE, RD_WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid, latch op/data.
    - WR_DT or WR_ST → WRITE.
    - RD_DT → RD_WAIT.
    - reserved → RESP with resp_err.
  - WRITE: req_ready = 0. Exactly one cycle of dt_we or st_we, with tmr_wdata = latched data. → RESP.
  - RD_WAIT: one cycle, to absorb the timer's registered output latency. → RESP.
  - RESP: resp_valid = 1 for one cycle.
    - RD_DT: resp_data = dt_value sampled this cycle.
    - Otherwise resp_data = 0.
    - → IDLE.
- Latency, acceptance to resp_valid:
  - Write: 2 cycles.
  - Read: 2 cycles.
  - Reserved op: 1 cycle.
- Back-to-back requests: next accept at earliest the cycle after RESP.
- req_op/req_data are sampled only when req_valid & req_ready.
- Read behind write: a RD_DT issued right after WR_DT returns the written value (guaranteed by RD_WAIT).
- A read coinciding with a tick returns either the pre-tick or post-tick value (timer semantics). Ticks are never delayed for reads.
- sound_on: registered copy of st_active, 1-cycle lag. Cleared in reset.
- Reset mid-transaction: FSM returns to IDLE; the in-flight request is dropped with no resp_valid; strobes deassert the same edge.

Optional Feature:
- Macro: CHIP8_TIMER_PAUSE_EN.
- When defined:
  - Adds input port pause (1 bit).
  - While pause = 1, the prescaler holds, raw_tick and tick_60 are 0, and tick_pending is preserved. Requests are still serviced.
  - sound_on is forced to 0 while paused.
- When undefined: no pause port; prescaler free-runs.

Decomposition:
- Package chip8_timer_pkg:
  - timer_op_t enum (WR_DT, WR_ST, RD_DT, OP_RSVD).
  - tctrl_state_t enum.
  - CLK_HZ = 50_000_000, TICK_HZ = 60, and CLK_DIV_DEFAULT = CLK_HZ/TICK_HZ.
- Sub-module tick_prescaler (parameter CLK_DIV; ports clk, reset, en, tick) holds the counter.
- Deferral logic and the FSM stay in chip8_timer_ctrl.

Test Plan:
- CLK_DIV = 4, no requests → tick_60 high one cycle in every 4 (cycles 3, 7, 11 after reset release); sound_on = 0.
- WR_DT 0x05 accepted at cycle 10 → dt_we = 1 at cycle 11 with tmr_wdata = 0x05; resp_valid at cycle 12; timer reaches 0 after 5 ticks.
- WR_ST issued so the st_we cycle equals a raw_tick cycle → tick_60 = 0 that cycle and 1 the next; total ticks over 100 cycles = 25.
- WR_DT 0x2A then immediate RD_DT → resp_data = 0x2A (or 0x29 if a tick intervened); resp_err = 0.
- req_op = 3 → resp_valid one cycle after accept, resp_err = 1, no we strobe; reset asserted during WRITE → no resp_valid, FSM IDLE, req_ready = 1 after reset.
- With CHIP8_TIMER_PAUSE_EN: pause high for 20 cycles → zero ticks and sound_on = 0; after release, next tick exactly (4 − count at pause) cycles later.

Source files
------------

// File: rtl/chip8_timer_pkg.sv
// Shared types and constants for the Chip-8 timer controller.
// Optional feature macro: CHIP8_TIMER_PAUSE_EN (see chip8_timer_ctrl.sv).
package chip8_timer_pkg;

    localparam int CLK_HZ          = 50_000_000;
    localparam int TICK_HZ         = 60;
    localparam int CLK_DIV_DEFAULT = CLK_HZ / TICK_HZ;

    // CPU timer request opcodes
    typedef enum logic [1:0] {
        WR_DT   = 2'd0,
        WR_ST   = 2'd1,
        RD_DT   = 2'd2,
        OP_RSVD = 2'd3
    } timer_op_t;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } tctrl_state_t;

endpackage

// File: rtl/chip8_timer_ctrl_if.sv
// CPU <-> timer controller request/response channel.
// master = CPU side, slave = controller side.
interface chip8_timer_ctrl_if;
    import chip8_timer_pkg::*;

    logic        req_valid;
    timer_op_t   req_op;
    logic [7:0]  req_data;
    logic        req_ready;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running modulo-CLK_DIV counter producing a one-cycle tick on the
// cycle the counter wraps. Holds its count while en is low.
module tick_prescaler
    import chip8_timer_pkg::*;
#(
    parameter  int CLK_DIV = CLK_DIV_DEFAULT,
    localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign tick   = en & w_wrap;

    // Count 0..CLK_DIV-1 and wrap; freeze while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/chip8_timer_ctrl.sv
// Chip-8 timer controller: 60 Hz tick generation with write-collision
// deferral, and a small FSM servicing CPU DT/ST requests.
// Optional feature macro: CHIP8_TIMER_PAUSE_EN adds a pause input that
// freezes the tick and silences the buzzer.
module chip8_timer_ctrl
    import chip8_timer_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    chip8_timer_ctrl_if.slave   bus,
    output logic                dt_we,
    output logic                st_we,
    output logic [7:0]          tmr_wdata,
    output logic                tick_60,
    input  logic [7:0]          dt_value,
    input  logic                st_active,
    output logic                sound_on
`ifdef CHIP8_TIMER_PAUSE_EN
    ,
    input  logic                pause
`endif
);

    tctrl_state_t r_state;
    tctrl_state_t w_state_nxt;
    timer_op_t    r_op;
    logic [7:0]   r_data;
    logic         r_tick_pending;
    logic         r_sound;

    logic         w_pause;
    logic         w_raw_tick;
    logic         w_we_any;
    logic         w_tick;
    logic         w_accept;
    logic         w_ready;
    logic         w_dt_we;
    logic         w_st_we;
    logic [7:0]   w_wdata;
    logic         w_resp_valid;
    logic [7:0]   w_resp_data;
    logic         w_resp_err;

`ifdef CHIP8_TIMER_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (~w_pause),
        .tick  (w_raw_tick)
    );

    // A tick that lands on a write strobe is held one cycle so the timer
    // sees the load and the decrement on separate cycles.
    assign w_we_any = w_dt_we | w_st_we;
    assign w_tick   = (w_raw_tick | r_tick_pending) & ~w_we_any & ~w_pause & ~reset;
    assign w_accept = bus.req_valid & w_ready;

    // Remember a tick swallowed by a write until it is issued
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_pending <= 1'b0;
        end else if (w_raw_tick & w_we_any) begin
            r_tick_pending <= 1'b1;
        end else if (w_tick) begin
            r_tick_pending <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the request only on a completed handshake
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op   <= bus.req_op;
            r_data <= bus.req_data;
        end
    end

    // Next state and per-state outputs; everything forced low during reset
    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = 1'b0;
        w_dt_we      = 1'b0;
        w_st_we      = 1'b0;
        w_wdata      = 8'h00;
        w_resp_valid = 1'b0;
        w_resp_data  = 8'h00;
        w_resp_err   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.req_valid) begin
                    case (bus.req_op)
                        WR_DT, WR_ST: w_state_nxt = WRITE;
                        RD_DT:        w_state_nxt = RD_WAIT;
                        default:      w_state_nxt = RESP;
                    endcase
                end
            end
            WRITE: begin
                w_dt_we     = (r_op == WR_DT);
                w_st_we     = (r_op == WR_ST);
                w_wdata     = r_data;
                w_state_nxt = RESP;
            end
            // Timer count is registered; one spare cycle lets a preceding
            // write become visible before it is read back.
            RD_WAIT: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                w_resp_valid = 1'b1;
                w_resp_err   = (r_op == OP_RSVD);
                if (r_op == RD_DT) begin
                    w_resp_data = dt_value;
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (reset) begin
            w_ready      = 1'b0;
            w_dt_we      = 1'b0;
            w_st_we      = 1'b0;
            w_wdata      = 8'h00;
            w_resp_valid = 1'b0;
            w_resp_data  = 8'h00;
            w_resp_err   = 1'b0;
        end
    end

    // Buzzer follows the sound timer's nonzero flag one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sound <= 1'b0;
        end else begin
            r_sound <= st_active;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_data  = w_resp_data;
    assign bus.resp_err   = w_resp_err;
    assign dt_we          = w_dt_we;
    assign st_we          = w_st_we;
    assign tmr_wdata      = w_wdata;
    assign tick_60        = w_tick;
    assign sound_on       = r_sound & ~w_pause & ~reset;

endmodule

// File: tb/tb_chip8_timer_ctrl.sv
// Self-checking bench for chip8_timer_ctrl with CLK_DIV = 4.
// The timer instances are modelled here and driven from the reference
// model's own strobes and ticks, so DUT outputs never feed expectations.
module tb_chip8_timer_ctrl;
    import chip8_timer_pkg::*;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       dt_we, st_we, tick_60, sound_on, st_active;
    logic [7:0] tmr_wdata, dt_value;
`ifdef CHIP8_TIMER_PAUSE_EN
    logic       pause;
`endif

    chip8_timer_ctrl_if bus();

    chip8_timer_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dt_we     (dt_we),
        .st_we     (st_we),
        .tmr_wdata (tmr_wdata),
        .tick_60   (tick_60),
        .dt_value  (dt_value),
        .st_active (st_active),
        .sound_on  (sound_on)
`ifdef CHIP8_TIMER_PAUSE_EN
        ,
        .pause     (pause)
`endif
    );

    always #5 clk = ~clk;

    int         n_cmp, n_bad;
    int         t;          // absolute cycle index
    int         ph;         // model prescaler phase
    bit         pend;       // model deferred tick
    bit         sprev;      // sound timer flag seen last cycle
    bit         pz;         // pause request (only drives the DUT when enabled)
    int         we_t, resp_t, ready_t;
    timer_op_t  m_op;
    logic [7:0] m_data, dtc, stc;
    int         tick_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, want %0d", tag, t, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic cyc(input bit v, input logic [1:0] op, input logic [7:0] d, input bit r);
        bit e_ready, e_dtwe, e_stwe, e_rv, e_err, e_raw, e_tick, e_snd;
        logic [7:0] e_wdata, e_rd;
        reset         = r;
        bus.req_valid = v;
        bus.req_op    = timer_op_t'(op);
        bus.req_data  = d;
        dt_value      = dtc;
        st_active     = (stc != 8'd0);
`ifdef CHIP8_TIMER_PAUSE_EN
        pause         = pz;
`endif
        #1;
        e_ready = 0; e_dtwe = 0; e_stwe = 0; e_rv = 0; e_err = 0;
        e_raw = 0; e_tick = 0; e_snd = 0; e_wdata = 8'h00; e_rd = 8'h00;
        if (!r) begin
            e_ready = (t >= ready_t);
            e_dtwe  = (t == we_t) && (m_op == WR_DT);
            e_stwe  = (t == we_t) && (m_op == WR_ST);
            e_wdata = (t == we_t) ? m_data : 8'h00;
            e_rv    = (t == resp_t);
            e_err   = e_rv && (m_op == OP_RSVD);
            e_rd    = (e_rv && m_op == RD_DT) ? dtc : 8'h00;
            e_raw   = (ph == CLK_DIV - 1) && !pz;
            e_tick  = (e_raw || pend) && !(e_dtwe || e_stwe) && !pz;
            e_snd   = sprev && !pz;
        end
        chk("req_ready",  bus.req_ready,  e_ready);
        chk("dt_we",      dt_we,          e_dtwe);
        chk("st_we",      st_we,          e_stwe);
        chk("tmr_wdata",  tmr_wdata,      e_wdata);
        chk("resp_valid", bus.resp_valid, e_rv);
        chk("resp_err",   bus.resp_err,   e_err);
        chk("resp_data",  bus.resp_data,  e_rd);
        chk("tick_60",    tick_60,        e_tick);
        chk("sound_on",   sound_on,       e_snd);
        if (tick_60) tick_cnt++;
        if (r) begin
            ph = 0; pend = 0; sprev = 0;
            we_t = -1; resp_t = -1; ready_t = t + 1;
        end else begin
            if (!pz) ph = (ph == CLK_DIV - 1) ? 0 : ph + 1;
            if (e_raw && (e_dtwe || e_stwe)) pend = 1;
            else if (e_tick)                  pend = 0;
            sprev = (stc != 8'd0);
            if (e_dtwe)                      dtc = m_data;
            else if (e_tick && dtc != 8'd0)  dtc = dtc - 8'd1;
            if (e_stwe)                      stc = m_data;
            else if (e_tick && stc != 8'd0)  stc = stc - 8'd1;
            if (v && e_ready) begin
                m_op   = timer_op_t'(op);
                m_data = d;
                case (timer_op_t'(op))
                    WR_DT, WR_ST: begin we_t = t + 1; resp_t = t + 2; end
                    RD_DT:        begin we_t = -1;    resp_t = t + 2; end
                    default:      begin we_t = -1;    resp_t = t + 1; end
                endcase
                ready_t = resp_t + 1;
            end
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 8'h00, 1'b0);
    endtask

    task automatic issue(input timer_op_t op, input logic [7:0] d);
        for (int g = 0; g < 10 && t < ready_t; g++) cyc(1'b0, 2'd0, 8'h00, 1'b0);
        cyc(1'b1, op, d, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; t = 0; ph = 0; pend = 0; sprev = 0; pz = 0;
        we_t = -1; resp_t = -1; ready_t = 0; m_op = WR_DT; m_data = 8'h00;
        dtc = 8'h00; stc = 8'h00; tick_cnt = 0;
        reset = 1'b1; bus.req_valid = 1'b0; bus.req_op = WR_DT; bus.req_data = 8'h00;
        dt_value = 8'h00; st_active = 1'b0;
`ifdef CHIP8_TIMER_PAUSE_EN
        pause = 1'b0;
`endif
        @(posedge clk); #1;
        cyc(1'b0, 2'd0, 8'h00, 1'b1);
        cyc(1'b0, 2'd0, 8'h00, 1'b1);

        // Free-running ticks, then a DT load that counts down
        idle(10);
        issue(WR_DT, 8'h05);
        idle(30);

        // Sound-timer write landing exactly on a raw tick, inside a 100-cycle window
        for (int g = 0; g < 20 && !(ph == 0 && t >= ready_t); g++) idle(1);
        tick_cnt = 0;
        idle(2);
        cyc(1'b1, WR_ST, 8'h03, 1'b0);
        idle(97);
        chk("ticks_per_100", tick_cnt, 25);

        // Read right behind write, reserved op
        issue(WR_DT, 8'h2A);
        issue(RD_DT, 8'h00);
        issue(OP_RSVD, 8'h77);
        idle(3);

        // Reset while the write strobe cycle is in progress
        issue(WR_DT, 8'h33);
        cyc(1'b0, 2'd0, 8'h00, 1'b1);
        idle(3);
        issue(RD_DT, 8'h00);

        // Buzzer on for a while
        issue(WR_ST, 8'h07);
        idle(40);

`ifdef CHIP8_TIMER_PAUSE_EN
        idle(1);
        pz = 1;
        idle(20);
        pz = 0;
        idle(10);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit         rr, vv;
            logic [1:0] oo;
            logic [7:0] dd;
            rr = ($urandom_range(0, 99) == 0);
            vv = ($urandom_range(0, 2) == 0);
            oo = 2'($urandom_range(0, 3));
            dd = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
`ifdef CHIP8_TIMER_PAUSE_EN
            if ($urandom_range(0, 15) == 0) pz = !pz;
`endif
            cyc(vv, oo, dd, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
